// File: rtl/register_file_if.sv
// Bundles the register file's write-back port, two read ports and scoreboard signals.
// The master side is the pipeline; the slave side is the register file itself.
interface register_file_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 6
);
  logic            w_en;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            issue_en;
  logic [AW-1:0]   issue_dest;
  logic            any_busy;

  modport master (
    output w_en, waddr, wdata, rs1_addr, rs2_addr, issue_en, issue_dest,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, any_busy
  );

  modport slave (
    input  w_en, waddr, wdata, rs1_addr, rs2_addr, issue_en, issue_dest,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, any_busy
  );
endinterface

// File: rtl/register_file.sv
// 64-entry x/f register file: negedge write commit, registered posedge reads, busy scoreboard.
// Optional RF_ZERO_ON_RESET_EN makes every entry read as zero after reset until rewritten.
module register_file #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned AW      = 6,
  parameter int unsigned ZERO_IX = 0
) (
  input  logic           clk,
  input  logic           reset,
  register_file_if.slave rf
);
  localparam int unsigned   DEPTH  = 1 << AW;
  localparam logic [AW-1:0] ZERO_A = AW'(ZERO_IX);

  logic [XLEN-1:0] mem_q [DEPTH];

  logic            commit_v_q, commit_v_d;
  logic [AW-1:0]   commit_addr_q, commit_addr_d;
  logic            wr_fire;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic             any_busy_q, any_busy_d;
  logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]  rs1_word, rs2_word;

  // The commit latch is only ever consumed by the following posedge, so reloading it
  // every negedge is equivalent to set-at-negedge / clear-at-posedge with one driver.
  always_comb begin
    commit_v_d    = rf.w_en & ~reset;
    commit_addr_d = rf.waddr;
    wr_fire       = commit_v_d && (rf.waddr != ZERO_A);
  end

  always_ff @(negedge clk) begin
    commit_v_q    <= commit_v_d;
    commit_addr_q <= commit_addr_d;
    if (wr_fire) begin
      mem_q[rf.waddr] <= rf.wdata;
    end
  end

`ifdef RF_ZERO_ON_RESET_EN
  // Per-entry written-since-reset flags emulate clearing the array at the reset posedge;
  // the pending commit is folded in so a write at the preceding negedge is still visible.
  logic [DEPTH-1:0] valid_q, valid_d;

  always_comb begin
    valid_d = valid_q;
    if (commit_v_q) begin
      valid_d[commit_addr_q] = 1'b1;
    end
    if (reset) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
  end

  always_comb begin
    rs1_word = (valid_q[rf.rs1_addr] || (commit_v_q && commit_addr_q == rf.rs1_addr))
               ? mem_q[rf.rs1_addr] : '0;
    rs2_word = (valid_q[rf.rs2_addr] || (commit_v_q && commit_addr_q == rf.rs2_addr))
               ? mem_q[rf.rs2_addr] : '0;
  end
`else
  always_comb begin
    rs1_word = mem_q[rf.rs1_addr];
    rs2_word = mem_q[rf.rs2_addr];
  end
`endif

  always_comb begin
    rs1_data_d = (rf.rs1_addr == ZERO_A) ? '0 : rs1_word;
    rs2_data_d = (rf.rs2_addr == ZERO_A) ? '0 : rs2_word;

    // Clear first so a same-address issue wins over the commit.
    busy_d = busy_q;
    if (commit_v_q) begin
      busy_d[commit_addr_q] = 1'b0;
    end
    if (rf.issue_en && (rf.issue_dest != ZERO_A)) begin
      busy_d[rf.issue_dest] = 1'b1;
    end
    busy_d[ZERO_A] = 1'b0;

    if (reset) begin
      rs1_data_d = '0;
      rs2_data_d = '0;
      busy_d     = '0;
    end
    any_busy_d = |busy_d;
  end

  always_ff @(posedge clk) begin
    busy_q     <= busy_d;
    any_busy_q <= any_busy_d;
    rs1_data_q <= rs1_data_d;
    rs2_data_q <= rs2_data_d;
  end

  assign rf.rs1_data = rs1_data_q;
  assign rf.rs2_data = rs2_data_q;
  assign rf.rs1_busy = busy_q[rf.rs1_addr];
  assign rf.rs2_busy = busy_q[rf.rs2_addr];
  assign rf.any_busy = any_busy_q;
endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, read/write, x0, f0, scoreboard.
module tb_register_file;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  register_file_if #(.XLEN(32), .AW(6)) rf_if ();

  register_file #(.XLEN(32), .AW(6), .ZERO_IX(0)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called during clk-high phase; leaves w_en high across exactly one negedge.
  task automatic drive_write(input logic [5:0] a, input logic [31:0] d);
    rf_if.w_en  = 1'b1;
    rf_if.waddr = a;
    rf_if.wdata = d;
    @(negedge clk);
    #1;
    rf_if.w_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rf_if.rs1_data !== 32'h0) begin failures++; $display("FAIL reset_rs1_data got=%h exp=%h", rf_if.rs1_data, 32'h0); end
    checks++; if (rf_if.rs2_data !== 32'h0) begin failures++; $display("FAIL reset_rs2_data got=%h exp=%h", rf_if.rs2_data, 32'h0); end
    checks++; if (rf_if.any_busy !== 1'b0) begin failures++; $display("FAIL reset_any_busy got=%b exp=0", rf_if.any_busy); end
    checks++; if (rf_if.rs1_busy !== 1'b0) begin failures++; $display("FAIL reset_rs1_busy got=%b exp=0", rf_if.rs1_busy); end
    checks++; if (rf_if.rs2_busy !== 1'b0) begin failures++; $display("FAIL reset_rs2_busy got=%b exp=0", rf_if.rs2_busy); end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    rf_if.rs1_addr = 6'd5;
    drive_write(6'd5, 32'hDEADBEEF);
    @(posedge clk); #1;
    checks++; if (rf_if.rs1_data !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd_5 got=%h exp=%h", rf_if.rs1_data, 32'hDEADBEEF); end
  endtask

  task automatic test_zero_and_f0();
    rf_if.rs1_addr = 6'd0;
    drive_write(6'd0, 32'h1234);
    @(posedge clk); #1;
    checks++; if (rf_if.rs1_data !== 32'h0) begin failures++; $display("FAIL x0_hardwired got=%h exp=%h", rf_if.rs1_data, 32'h0); end
    rf_if.rs2_addr = 6'd32;
    drive_write(6'd32, 32'h1234);
    @(posedge clk); #1;
    checks++; if (rf_if.rs2_data !== 32'h1234) begin failures++; $display("FAIL f0_ordinary got=%h exp=%h", rf_if.rs2_data, 32'h1234); end
  endtask

  task automatic test_scoreboard();
    rf_if.rs1_addr   = 6'd7;
    rf_if.issue_en   = 1'b1;
    rf_if.issue_dest = 6'd7;
    @(posedge clk); #1;
    rf_if.issue_en = 1'b0;
    checks++; if (rf_if.rs1_busy !== 1'b1) begin failures++; $display("FAIL issue7_rs1_busy got=%b exp=1", rf_if.rs1_busy); end
    checks++; if (rf_if.any_busy !== 1'b1) begin failures++; $display("FAIL issue7_any_busy got=%b exp=1", rf_if.any_busy); end
    drive_write(6'd7, 32'h0000_0777);
    checks++; if (rf_if.rs1_busy !== 1'b1) begin failures++; $display("FAIL commit7_before_posedge got=%b exp=1", rf_if.rs1_busy); end
    @(posedge clk); #1;
    checks++; if (rf_if.rs1_busy !== 1'b0) begin failures++; $display("FAIL commit7_rs1_busy got=%b exp=0", rf_if.rs1_busy); end
    checks++; if (rf_if.any_busy !== 1'b0) begin failures++; $display("FAIL commit7_any_busy got=%b exp=0", rf_if.any_busy); end
    checks++; if (rf_if.rs1_data !== 32'h0000_0777) begin failures++; $display("FAIL commit7_data got=%h exp=%h", rf_if.rs1_data, 32'h0000_0777); end
  endtask

  task automatic test_set_wins();
    rf_if.rs2_addr   = 6'd9;
    rf_if.issue_en   = 1'b1;
    rf_if.issue_dest = 6'd9;
    @(posedge clk); #1;
    drive_write(6'd9, 32'h99);
    @(posedge clk); #1;
    rf_if.issue_en = 1'b0;
    checks++; if (rf_if.rs2_busy !== 1'b1) begin failures++; $display("FAIL set_wins_rs2_busy got=%b exp=1", rf_if.rs2_busy); end
    checks++; if (rf_if.any_busy !== 1'b1) begin failures++; $display("FAIL set_wins_any_busy got=%b exp=1", rf_if.any_busy); end
    rf_if.rs1_addr   = 6'd0;
    rf_if.issue_en   = 1'b1;
    rf_if.issue_dest = 6'd0;
    @(posedge clk); #1;
    rf_if.issue_en = 1'b0;
    checks++; if (rf_if.rs1_busy !== 1'b0) begin failures++; $display("FAIL issue_x0_busy got=%b exp=0", rf_if.rs1_busy); end
    drive_write(6'd9, 32'h77);
    @(posedge clk); #1;
    checks++; if (rf_if.rs2_busy !== 1'b0) begin failures++; $display("FAIL reissue_single_clear got=%b exp=0", rf_if.rs2_busy); end
    checks++; if (rf_if.any_busy !== 1'b0) begin failures++; $display("FAIL drain_any_busy got=%b exp=0", rf_if.any_busy); end
    checks++; if (rf_if.rs2_data !== 32'h77) begin failures++; $display("FAIL reg9_data got=%h exp=%h", rf_if.rs2_data, 32'h77); end
  endtask

  task automatic test_back_to_back();
    rf_if.rs1_addr = 6'd10;
    rf_if.rs2_addr = 6'd10;
    drive_write(6'd10, 32'h1111_1111);
    @(posedge clk); #1;
    checks++; if (rf_if.rs1_data !== 32'h1111_1111) begin failures++; $display("FAIL same_addr_rs1 got=%h exp=%h", rf_if.rs1_data, 32'h1111_1111); end
    checks++; if (rf_if.rs2_data !== 32'h1111_1111) begin failures++; $display("FAIL same_addr_rs2 got=%h exp=%h", rf_if.rs2_data, 32'h1111_1111); end
    rf_if.rs1_addr = 6'd11;
    drive_write(6'd11, 32'h2222_2222);
    @(posedge clk); #1;
    checks++; if (rf_if.rs1_data !== 32'h2222_2222) begin failures++; $display("FAIL b2b_rs1 got=%h exp=%h", rf_if.rs1_data, 32'h2222_2222); end
    checks++; if (rf_if.rs2_data !== 32'h1111_1111) begin failures++; $display("FAIL b2b_rs2 got=%h exp=%h", rf_if.rs2_data, 32'h1111_1111); end
  endtask

  task automatic test_reset_retention();
    logic [31:0] exp_after;
`ifdef RF_ZERO_ON_RESET_EN
    exp_after = 32'h0;
`else
    exp_after = 32'hA5A5;
`endif
    rf_if.rs1_addr = 6'd3;
    drive_write(6'd3, 32'hA5A5);
    @(posedge clk); #1;
    checks++; if (rf_if.rs1_data !== 32'hA5A5) begin failures++; $display("FAIL reg3_before_reset got=%h exp=%h", rf_if.rs1_data, 32'hA5A5); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (rf_if.rs1_data !== 32'h0) begin failures++; $display("FAIL reg3_during_reset got=%h exp=%h", rf_if.rs1_data, 32'h0); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (rf_if.rs1_data !== exp_after) begin failures++; $display("FAIL reg3_after_reset got=%h exp=%h", rf_if.rs1_data, exp_after); end
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    reset            = 1'b1;
    rf_if.w_en       = 1'b0;
    rf_if.waddr      = '0;
    rf_if.wdata      = '0;
    rf_if.rs1_addr   = '0;
    rf_if.rs2_addr   = '0;
    rf_if.issue_en   = 1'b0;
    rf_if.issue_dest = '0;
    test_reset();
    test_write_read();
    test_zero_and_f0();
    test_scoreboard();
    test_set_wins();
    test_back_to_back();
    test_reset_retention();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
